// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and dispatch with branch-hazard flush and fetch redirect.
// Optional register pre-decode storage is enabled by defining FETCHQ_PREDECODE_EN.
module fetch_queue #(
    parameter int DEPTH   = 16,
    parameter int IN_WAY  = 2,
    parameter int OUT_WAY = 2,
    parameter int XLEN    = 32
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [IN_WAY-1:0]                in_valid,
    input  logic [IN_WAY-1:0][31:0]          in_inst,
    input  logic [IN_WAY-1:0][XLEN-1:0]      in_pc,
    output logic                             in_ready,
    input  logic [OUT_WAY-1:0]               dispatched,
    input  logic                             branch_haz,
    input  logic [XLEN-1:0]                  br_target,
    output logic [OUT_WAY-1:0]               out_valid,
    output logic [OUT_WAY-1:0][31:0]         out_inst,
    output logic [OUT_WAY-1:0][XLEN-1:0]     out_pc,
    output logic [OUT_WAY-1:0][XLEN-1:0]     out_npc,
    output logic [OUT_WAY-1:0][4:0]          out_src1,
    output logic [OUT_WAY-1:0][4:0]          out_src2,
    output logic [OUT_WAY-1:0][4:0]          out_dest,
    output logic [OUT_WAY-1:0]               out_branch,
    output logic                             fetch_redirect,
    output logic [XLEN-1:0]                  fetch_pc,
    output logic [$clog2(DEPTH):0]           count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]     ONE_C  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]     LIMIT_C = (PW+1)'(DEPTH - IN_WAY);
    localparam logic [XLEN-1:0] FOUR_C = {{(XLEN-3){1'b0}}, 3'b100};

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW:0]     count_q, count_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] fpc_q, fpc_d;

    logic [31:0]     inst_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];

    logic [PW:0]     push_cnt_s;
    logic [PW:0]     pop_cnt_s;
    logic            pop_run_s;

    // Occupancy-derived handshake and push size (no credit for same-cycle pops)
    always_comb begin
        in_ready   = (count_q <= LIMIT_C);
        count      = count_q;
        push_cnt_s = '0;
        for (int i = 0; i < IN_WAY; i++) begin
            if (in_ready && in_valid[i]) begin
                push_cnt_s = push_cnt_s + ONE_C;
            end else begin
                push_cnt_s = push_cnt_s;
            end
        end
    end

    // Present entries head+i; a pending flush hides every lane immediately
    always_comb begin
        out_valid = '0;
        out_inst  = '0;
        out_pc    = '0;
        out_npc   = '0;
        for (int i = 0; i < OUT_WAY; i++) begin
            if (((PW+1)'(i) < count_q) && !branch_haz) begin
                out_valid[i] = 1'b1;
                out_inst[i]  = inst_q[head_q + PW'(i)];
                out_pc[i]    = pc_q[head_q + PW'(i)];
                out_npc[i]   = pc_q[head_q + PW'(i)] + FOUR_C;
            end else begin
                out_valid[i] = 1'b0;
            end
        end
    end

    // Pop count is the run of leading ones in the accepted dispatch mask
    always_comb begin
        pop_cnt_s = '0;
        pop_run_s = 1'b1;
        for (int i = 0; i < OUT_WAY; i++) begin
            if (pop_run_s && dispatched[i] && out_valid[i]) begin
                pop_cnt_s = pop_cnt_s + ONE_C;
            end else begin
                pop_run_s = 1'b0;
            end
        end
    end

    // Pointer, occupancy and redirect next-state; flush overrides push/pop
    always_comb begin
        head_d     = head_q + PW'(pop_cnt_s);
        tail_d     = tail_q + PW'(push_cnt_s);
        count_d    = count_q + push_cnt_s - pop_cnt_s;
        redirect_d = 1'b0;
        fpc_d      = fpc_q;
        if (branch_haz) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            redirect_d = 1'b1;
            fpc_d      = {br_target[XLEN-1:2], 2'b00};
        end else begin
            redirect_d = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            redirect_q <= 1'b0;
            fpc_q      <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            redirect_q <= redirect_d;
            fpc_q      <= fpc_d;
        end
    end

    assign fetch_redirect = redirect_q;
    assign fetch_pc       = fpc_q;

    // Payload storage; validity is tracked solely by head/count so no reset is needed
    always_ff @(posedge clock) begin
        for (int i = 0; i < IN_WAY; i++) begin
            if (in_ready && in_valid[i] && !branch_haz) begin
                inst_q[tail_q + PW'(i)] <= in_inst[i];
                pc_q[tail_q + PW'(i)]   <= in_pc[i];
            end
        end
    end

`ifdef FETCHQ_PREDECODE_EN
    typedef struct packed {
        logic       branch;
        logic [4:0] dest;
        logic [4:0] src2;
        logic [4:0] src1;
    } pd_t;

    pd_t pd_q [DEPTH];

    function automatic pd_t predecode(input logic [31:0] inst);
        pd_t pd;
        pd = '0;
        case (inst[6:0])
            7'b0110111, 7'b0010111, 7'b1101111: begin
                pd.dest = inst[11:7];
            end
            7'b1100111, 7'b0000011, 7'b0010011: begin
                pd.dest = inst[11:7];
                pd.src1 = inst[19:15];
            end
            7'b0110011: begin
                pd.dest = inst[11:7];
                pd.src1 = inst[19:15];
                pd.src2 = inst[24:20];
            end
            7'b1100011: begin
                pd.src1   = inst[19:15];
                pd.src2   = inst[24:20];
                pd.branch = 1'b1;
            end
            7'b0100011: begin
                pd.src1 = inst[19:15];
                pd.src2 = inst[24:20];
            end
            default: begin
                pd = '0;
            end
        endcase
        return pd;
    endfunction

    // Pre-decoded operand storage, written alongside the payload
    always_ff @(posedge clock) begin
        for (int i = 0; i < IN_WAY; i++) begin
            if (in_ready && in_valid[i] && !branch_haz) begin
                pd_q[tail_q + PW'(i)] <= predecode(in_inst[i]);
            end
        end
    end

    // Drive pre-decoded fields only for lanes that are presented
    always_comb begin
        out_src1   = '0;
        out_src2   = '0;
        out_dest   = '0;
        out_branch = '0;
        for (int i = 0; i < OUT_WAY; i++) begin
            if (out_valid[i]) begin
                out_src1[i]   = pd_q[head_q + PW'(i)].src1;
                out_src2[i]   = pd_q[head_q + PW'(i)].src2;
                out_dest[i]   = pd_q[head_q + PW'(i)].dest;
                out_branch[i] = pd_q[head_q + PW'(i)].branch;
            end else begin
                out_branch[i] = 1'b0;
            end
        end
    end
`else
    assign out_src1   = '0;
    assign out_src2   = '0;
    assign out_dest   = '0;
    assign out_branch = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=16, IN_WAY=2, OUT_WAY=2, XLEN=32).
module tb_fetch_queue;

    logic              clock;
    logic              reset_n;
    logic [1:0]        in_valid;
    logic [1:0][31:0]  in_inst;
    logic [1:0][31:0]  in_pc;
    logic              in_ready;
    logic [1:0]        dispatched;
    logic              branch_haz;
    logic [31:0]       br_target;
    logic [1:0]        out_valid;
    logic [1:0][31:0]  out_inst;
    logic [1:0][31:0]  out_pc;
    logic [1:0][31:0]  out_npc;
    logic [1:0][4:0]   out_src1;
    logic [1:0][4:0]   out_src2;
    logic [1:0][4:0]   out_dest;
    logic [1:0]        out_branch;
    logic              fetch_redirect;
    logic [31:0]       fetch_pc;
    logic [4:0]        count;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADD_C = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] BEQ_C = 32'h00520063; // beq x4,x5,0

    fetch_queue #(.DEPTH(16), .IN_WAY(2), .OUT_WAY(2), .XLEN(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
        .dispatched(dispatched), .branch_haz(branch_haz), .br_target(br_target),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_npc(out_npc),
        .out_src1(out_src1), .out_src2(out_src2), .out_dest(out_dest), .out_branch(out_branch),
        .fetch_redirect(fetch_redirect), .fetch_pc(fetch_pc), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] wpc(input int n);
        return 32'h0000_1000 + 32'(n * 4);
    endfunction

    initial begin
        clock = 1'b0; reset_n = 1'b0;
        in_valid = 2'b00; in_inst = '0; in_pc = '0;
        dispatched = 2'b00; branch_haz = 1'b0; br_target = 32'h0;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_redirect", 64'(fetch_redirect), 64'd0);
        chk("rst_fetch_pc", 64'(fetch_pc), 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        tick();
        reset_n = 1'b1;

        // ADD at PC 0, BEQ at PC 4
        in_valid = 2'b11; in_inst[0] = ADD_C; in_inst[1] = BEQ_C; in_pc[0] = 32'h0; in_pc[1] = 32'h4;
        tick();
        in_valid = 2'b00; #1;
        chk("pair_valid", 64'(out_valid), 64'h3);
        chk("pair_inst", 64'(out_inst), {BEQ_C, ADD_C});
        chk("pair_pc", 64'(out_pc), {32'h4, 32'h0});
        chk("pair_npc", 64'(out_npc), {32'h8, 32'h4});
        chk("pair_count", 64'(count), 64'd2);
`ifdef FETCHQ_PREDECODE_EN
        chk("pair_dest", 64'(out_dest), 64'({5'd0, 5'd3}));
        chk("pair_src1", 64'(out_src1), 64'({5'd4, 5'd1}));
        chk("pair_src2", 64'(out_src2), 64'({5'd5, 5'd2}));
        chk("pair_branch", 64'(out_branch), 64'h2);
`else
        chk("pair_dest", 64'(out_dest), 64'd0);
        chk("pair_src2", 64'(out_src2), 64'd0);
        chk("pair_branch", 64'(out_branch), 64'd0);
`endif

        // non-prefix dispatch pops nothing, then a single pop shifts lanes
        dispatched = 2'b10; tick(); dispatched = 2'b00; #1;
        chk("d10_count", 64'(count), 64'd2);
        chk("d10_pc", 64'(out_pc), {32'h4, 32'h0});
        dispatched = 2'b01; tick(); dispatched = 2'b00; #1;
        chk("d01_count", 64'(count), 64'd1);
        chk("d01_valid", 64'(out_valid), 64'h1);
        chk("d01_pc", 64'(out_pc), {32'h0, 32'h4});
        chk("d01_inst", 64'(out_inst), {32'h0, BEQ_C});
        dispatched = 2'b01; tick(); dispatched = 2'b00; #1;
        chk("drain_count", 64'(count), 64'd0);

        // fill to full
        for (int k = 0; k < 7; k++) begin
            in_valid = 2'b11; in_inst[0] = ADD_C; in_inst[1] = ADD_C;
            in_pc[0] = 32'h100 + 32'(8 * k); in_pc[1] = 32'h104 + 32'(8 * k);
            tick();
        end
        in_valid = 2'b00; #1;
        chk("c14_count", 64'(count), 64'd14);
        chk("c14_ready", 64'(in_ready), 64'd1);
        in_valid = 2'b11; in_pc[0] = 32'h138; in_pc[1] = 32'h13C;
        tick();
        in_pc[0] = 32'h999; in_pc[1] = 32'h99D; #1;
        chk("full_count", 64'(count), 64'd16);
        chk("full_ready", 64'(in_ready), 64'd0);
        tick();
        in_valid = 2'b00; #1;
        chk("drop_count", 64'(count), 64'd16);
        chk("drop_head_pc", 64'(out_pc), {32'h104, 32'h100});
        dispatched = 2'b11; tick(); dispatched = 2'b00; #1;
        chk("pop2_count", 64'(count), 64'd14);
        chk("pop2_ready", 64'(in_ready), 64'd1);
        chk("pop2_pc", 64'(out_pc), {32'h10C, 32'h108});

        // drain to 5 and flush with concurrent push/pop requests
        dispatched = 2'b11;
        for (int k = 0; k < 4; k++) tick();
        dispatched = 2'b01; tick(); dispatched = 2'b00; #1;
        chk("pre_flush_count", 64'(count), 64'd5);
        branch_haz = 1'b1; br_target = 32'h106; in_valid = 2'b11; dispatched = 2'b11; #1;
        chk("flush_same_valid", 64'(out_valid), 64'd0);
        tick();
        branch_haz = 1'b0; in_valid = 2'b00; dispatched = 2'b00; #1;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_redirect", 64'(fetch_redirect), 64'd1);
        chk("flush_fetch_pc", 64'(fetch_pc), 64'h104);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("flush_redirect_off", 64'(fetch_redirect), 64'd0);
        chk("flush_pc_hold", 64'(fetch_pc), 64'h104);

        // back-to-back flushes
        branch_haz = 1'b1; br_target = 32'h200; tick();
        chk("b2b1_redirect", 64'(fetch_redirect), 64'd1);
        chk("b2b1_pc", 64'(fetch_pc), 64'h200);
        br_target = 32'h30B; tick();
        branch_haz = 1'b0; #1;
        chk("b2b2_redirect", 64'(fetch_redirect), 64'd1);
        chk("b2b2_pc", 64'(fetch_pc), 64'h308);
        tick();
        chk("b2b_off", 64'(fetch_redirect), 64'd0);

        // walk head to 14 keeping two entries, then four entries across the wrap
        in_valid = 2'b11; in_inst[0] = ADD_C; in_inst[1] = ADD_C;
        in_pc[0] = wpc(0); in_pc[1] = wpc(1);
        tick();
        dispatched = 2'b11;
        for (int k = 1; k < 8; k++) begin
            in_pc[0] = wpc(2 * k); in_pc[1] = wpc(2 * k + 1);
            tick();
        end
        dispatched = 2'b00; in_pc[0] = wpc(16); in_pc[1] = wpc(17);
        tick();
        in_valid = 2'b00; #1;
        chk("wrap_pre_count", 64'(count), 64'd4);
        chk("wrap_pre_pc", 64'(out_pc), {wpc(15), wpc(14)});
        in_valid = 2'b11; in_pc[0] = wpc(18); in_pc[1] = wpc(19); dispatched = 2'b11;
        tick();
        in_valid = 2'b00; dispatched = 2'b00; #1;
        chk("wrap_count", 64'(count), 64'd4);
        chk("wrap_pc", 64'(out_pc), {wpc(17), wpc(16)});
        dispatched = 2'b11; tick(); dispatched = 2'b00; #1;
        chk("wrap_tail_pc", 64'(out_pc), {wpc(19), wpc(18)});
        chk("wrap_tail_count", 64'(count), 64'd2);

        // asynchronous reset mid-cycle
        in_valid = 2'b11; #3;
        reset_n = 1'b0; #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_fetch_pc", 64'(fetch_pc), 64'd0);
        chk("arst_pd", 64'({out_src1, out_src2, out_dest, out_branch}), 64'd0);
        in_valid = 2'b00;
        tick();
        reset_n = 1'b1;
        in_valid = 2'b01; in_inst[0] = ADD_C; in_pc[0] = 32'h40;
        tick();
        in_valid = 2'b00; #1;
        chk("post_rst_valid", 64'(out_valid), 64'h1);
        chk("post_rst_count", 64'(count), 64'd1);
        chk("post_rst_pc", 64'(out_pc), {32'h0, 32'h40});
`ifdef FETCHQ_PREDECODE_EN
        chk("post_rst_dest", 64'(out_dest), 64'({5'd0, 5'd3}));
`else
        chk("post_rst_dest", 64'(out_dest), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised circular instruction queue between the fetch stage and the R10K dispatch stage. Accepts up to `IN_WAY` instructions per cycle, pre-decodes register operands, and presents up to `OUT_WAY` in-order entries for dispatch. It is the next generation of the fixed-width dispatch feeder: depth and widths are independent, and storage is decoupled from fetch. A branch hazard flushes all queued entries and emits a registered fetch redirect.

## Interface
- `DEPTH`, 16: entry count; power of two; `DEPTH >= IN_WAY + OUT_WAY`.
- `IN_WAY`, 2: instructions accepted per cycle.
- `OUT_WAY`, `N_WAY`: entries presented per cycle.
- `XLEN`, 32: PC width.
- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in IN_WAY: enqueue mask; a contiguous prefix from bit 0.
- `in_inst` in IN_WAY×32: instruction words.
- `in_pc` in IN_WAY×XLEN: PC of each instruction.
- `in_ready` out 1: free slots ≥ IN_WAY.
- `dispatched` in OUT_WAY: consumed mask from dispatch.
- `branch_haz` in 1: flush request.
- `br_target` in XLEN: redirect target.
- `out_valid` out OUT_WAY: entry i present.
- `out_inst` out OUT_WAY×32, `out_pc` / `out_npc` out OUT_WAY×XLEN: instruction, PC, PC+4.
- `out_src1` / `out_src2` / `out_dest` out OUT_WAY×5: pre-decoded architectural registers.
- `out_branch` out OUT_WAY: conditional-branch flag.
- `fetch_redirect` out 1, `fetch_pc` out XLEN: registered redirect to fetch.
- `count` out $clog2(DEPTH)+1: occupied entries.

## Operation
- Storage is a DEPTH-entry circular array with `head` and `tail` pointers of width $clog2(DEPTH). Pointers wrap modulo DEPTH, and `count` disambiguates full from empty.
- Enqueue:
  - Occurs when `in_ready` is high.
  - Writes each `in_valid` lane to `tail+i`; `tail` advances by popcount(`in_valid`).
  - When `in_ready` is low, input is ignored, and fetch holds it.
- Output: lane i shows entry `head+i` when `i < count`, else `out_valid[i]=0` and all of lane i's fields are 0.
- Dequeue:
  - Pops the number of leading ones in `dispatched & out_valid`.
  - Any bits after the first zero are ignored; e.g. `2'b10` pops 0 entries.
- Simultaneous enqueue and dequeue: `count_next = count + pushed - popped`.
  - `in_ready` uses the current `count` only, with no credit for same-cycle pops.
- Flush (`branch_haz=1`) has priority over all other activity:
  - `out_valid` is forced to 0 combinationally in the same cycle.
  - At the next edge `head=tail=count=0`, and that cycle's enqueue and dequeue are discarded.
  - `fetch_redirect<=1` and `fetch_pc<=br_target & ~3` for exactly one cycle; otherwise `fetch_redirect<=0` and `fetch_pc` holds its value.
  - Back-to-back flushes each produce a redirect, with the latest target.
- Pre-decode is performed at enqueue and stored per entry:
  - dest = rd for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP (including MUL*); else 0.
  - src1 = rs1 except for LUI, AUIPC and JAL (0).
  - src2 = rs2 for OP, BRANCH and STORE; else 0.
  - branch = 1 only for opcode BRANCH (1100011).
  - An unknown opcode gives all pre-decode fields 0, but the entry is still valid.

## Timing
- Reset values: all pointers, `count`, and `fetch_pc` = 0; all outputs 0 except `in_ready=1`.
- Reset may assert mid-operation; the contents are discarded immediately.
- Enqueue-to-output latency is 1 cycle: an entry written at edge N is visible after edge N.
- Pop takes effect at the edge; the next entries appear the following cycle.
- `in_ready` and `count` are combinational from registered state.
- `fetch_redirect` is high the cycle after `branch_haz`.
- Full case: with `count > DEPTH-IN_WAY`, `in_ready=0`, and no entry is overwritten.

## Configuration
- `FETCHQ_PREDECODE_EN` defined: pre-decode logic is present, and the src/dest/branch fields are stored and driven as above.
- `FETCHQ_PREDECODE_EN` undefined:
  - No pre-decode storage.
  - `out_src1`, `out_src2`, `out_dest` and `out_branch` are tied to 0; dispatch decodes instead.
  - All other behaviour is unchanged.

## Test plan
- Reset, then enqueue `ADD x3,x1,x2` at PC 0 and `BEQ x4,x5` at PC 4 → next cycle `out_valid=2'b11`, `out_dest={0,3}`, `out_src2={5,2}`, `out_branch={1,0}`, `out_npc={8,4}`, `count=2`.
- Fill with 16 pushes without dispatching → `count=16`, `in_ready=0`; an extra push is dropped. Pop 2 → `in_ready=1`.
- `dispatched=2'b10` with 2 valid entries → nothing popped, `count` unchanged; `2'b01` → 1 popped, old entry 1 becomes lane 0.
- Simultaneous push of 2 and pop of 2 at `count=4` across the pointer wrap (head=14) → `count=4`, PC order preserved.
- `branch_haz=1`, `br_target=0x106` with 5 queued → same-cycle `out_valid=0`; next cycle `count=0`, `fetch_redirect=1`, `fetch_pc=0x104`; the cycle after, `fetch_redirect=0`.
- Deassert `reset_n` asynchronously mid-stream → outputs clear immediately; with `FETCHQ_PREDECODE_EN` undefined, the src/dest/branch outputs stay 0 throughout.
